// File: rtl/rv32i_types.sv
// Shared core types and widths: the CDB result record and the rename/ROB/RS tag widths.
package rv32i_types;

    localparam int NUM_FU         = 2;
    localparam int CDB_FIFO_DEPTH = 2;
    localparam int PS_W           = 6;
    localparam int AR_W           = 5;
    localparam int ROB_W          = 4;

    typedef struct packed {
        logic [PS_W-1:0]  pd;
        logic [AR_W-1:0]  rd;
        logic [ROB_W-1:0] rob;
        logic [31:0]      data;
    } cdb_result_t;

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-FU result FIFO: power-of-2 depth, synchronous reset, single-cycle flush clear.
module cdb_result_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage is not reset; only the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/cdb_broadcast_arbiter.sv
// CDB transmit side: per-FU result FIFOs, one grant per cycle, registered broadcast.
// Define CDB_RR_ARB_EN for round-robin arbitration; default is fixed priority (FU 0 wins).
module cdb_broadcast_arbiter
    import rv32i_types::cdb_result_t;
#(
    parameter int NUM_FU     = rv32i_types::NUM_FU,
    parameter int FIFO_DEPTH = rv32i_types::CDB_FIFO_DEPTH,
    parameter int PS_W       = rv32i_types::PS_W,
    parameter int AR_W       = rv32i_types::AR_W,
    parameter int ROB_W      = rv32i_types::ROB_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_FU-1:0]       fu_valid,
    input  logic [NUM_FU*PS_W-1:0]  fu_pd,
    input  logic [NUM_FU*AR_W-1:0]  fu_rd,
    input  logic [NUM_FU*ROB_W-1:0] fu_rob,
    input  logic [NUM_FU*32-1:0]    fu_data,
    output logic [NUM_FU-1:0]       fu_busy,
    output logic                    cdb_valid,
    output logic [PS_W-1:0]         cdb_pd,
    output logic [AR_W-1:0]         cdb_rd,
    output logic [ROB_W-1:0]        cdb_rob,
    output logic [31:0]             cdb_data
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    // Handshake: a result transfers at the edge where fu_valid[i]=1 and fu_busy[i]=0.
    // fu_busy comes straight from the registered count, so a same-cycle pop never lowers it;
    // a busy FU keeps its result and presents it again once busy drops.

    cdb_result_t      head [NUM_FU];
    logic [CNT_W-1:0] cnt  [NUM_FU];
    logic [NUM_FU-1:0] empty;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic              gnt_any;
    logic [IDX_W-1:0]  gnt_idx;
    cdb_result_t       cdb_q;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        cdb_result_t fu_res;

        assign fu_res.pd   = fu_pd[i*PS_W +: PS_W];
        assign fu_res.rd   = fu_rd[i*AR_W +: AR_W];
        assign fu_res.rob  = fu_rob[i*ROB_W +: ROB_W];
        assign fu_res.data = fu_data[i*32 +: 32];

        assign fu_busy[i] = (cnt[i] == CNT_W'(FIFO_DEPTH));
        assign empty[i]   = (cnt[i] == '0);
        assign push[i]    = fu_valid[i] && !fu_busy[i] && !flush;
        assign pop[i]     = gnt_any && (gnt_idx == IDX_W'(i)) && !flush;

        cdb_result_fifo #(
            .W     ($bits(cdb_result_t)),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[i]),
            .din   (fu_res),
            .pop   (pop[i]),
            .head  (head[i]),
            .count (cnt[i])
        );

        a_no_push_while_busy : assert property (
            @(posedge clk) disable iff (rst) !(fu_valid[i] && fu_busy[i]));
    end

`ifdef CDB_RR_ARB_EN
    logic [IDX_W-1:0] rr_ptr;

    // Search starts at the pointer so every non-empty FIFO is reached within NUM_FU grants.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!gnt_any && !empty[IDX_W'((int'(rr_ptr) + k) % NUM_FU)]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'((int'(rr_ptr) + k) % NUM_FU);
            end
        end
    end

    // Flush cancels the grant, so the pointer only moves on grants that actually pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (gnt_any && !flush) begin
            rr_ptr <= (gnt_idx == IDX_W'(NUM_FU - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!gnt_any && !empty[k]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(k);
            end
        end
    end
`endif

    // Fields are zeroed whenever nothing broadcasts; p0 is never allocated, so it wakes nothing.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cdb_valid <= 1'b0;
            cdb_q     <= '0;
        end else begin
            cdb_valid <= gnt_any;
            cdb_q     <= gnt_any ? head[gnt_idx] : '0;
        end
    end

    assign cdb_pd   = cdb_q.pd;
    assign cdb_rd   = cdb_q.rd;
    assign cdb_rob  = cdb_q.rob;
    assign cdb_data = cdb_q.data;

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Directed bench for cdb_broadcast_arbiter; covers both arbitration builds via CDB_RR_ARB_EN.
module tb_cdb_broadcast_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [1:0]  fu_valid;
    logic [11:0] fu_pd;
    logic [9:0]  fu_rd;
    logic [7:0]  fu_rob;
    logic [63:0] fu_data;
    logic [1:0]  fu_busy;
    logic        cdb_valid;
    logic [5:0]  cdb_pd;
    logic [4:0]  cdb_rd;
    logic [3:0]  cdb_rob;
    logic [31:0] cdb_data;

    int n_cmp = 0;
    int n_bad = 0;

    cdb_broadcast_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .fu_valid  (fu_valid),
        .fu_pd     (fu_pd),
        .fu_rd     (fu_rd),
        .fu_rob    (fu_rob),
        .fu_data   (fu_data),
        .fu_busy   (fu_busy),
        .cdb_valid (cdb_valid),
        .cdb_pd    (cdb_pd),
        .cdb_rd    (cdb_rd),
        .cdb_rob   (cdb_rob),
        .cdb_data  (cdb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] bus_of(input logic v, input logic [5:0] pd, input logic [4:0] rd,
                                           input logic [3:0] rob, input logic [31:0] data);
        return {v, pd, rd, rob, data};
    endfunction

    function automatic logic [31:0] data_of(input logic [5:0] pd);
        return 32'hC0DE_0000 | {26'd0, pd};
    endfunction

    // Results driven by step() use fields derived from the tag: rd=pd[4:0], rob=pd[3:0].
    task automatic set_fu(input int i, input logic v, input logic [5:0] pd);
        fu_valid[i]        = v;
        fu_pd[i*6 +: 6]    = v ? pd : 6'd0;
        fu_rd[i*5 +: 5]    = v ? pd[4:0] : 5'd0;
        fu_rob[i*4 +: 4]   = v ? pd[3:0] : 4'd0;
        fu_data[i*32 +: 32] = v ? data_of(pd) : 32'd0;
    endtask

    // Check busy and bus for the current cycle, then drive this cycle's FU inputs and advance.
    task automatic step(input string tag, input logic av, input logic [5:0] apd,
                        input logic mv, input logic [5:0] mpd,
                        input logic [1:0] eb, input logic ev, input logic [5:0] epd);
        chk({tag, "/busy"}, 64'(fu_busy), 64'(eb));
        chk({tag, "/cdb"}, 64'({cdb_valid, cdb_pd, cdb_rd, cdb_rob, cdb_data}),
            64'(ev ? bus_of(1'b1, epd, epd[4:0], epd[3:0], data_of(epd)) : 48'd0));
        set_fu(0, av, apd);
        set_fu(1, mv, mpd);
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        fu_valid = '0;
        fu_pd    = '0;
        fu_rd    = '0;
        fu_rob   = '0;
        fu_data  = '0;

        // Reset held two cycles
        tick();
        tick();
        chk("reset/busy", 64'(fu_busy), 64'd0);
        chk("reset/cdb", 64'({cdb_valid, cdb_pd, cdb_rd, cdb_rob, cdb_data}), 64'd0);
        rst = 1'b0;

        // Single add result: visible two cycles after acceptance, for one cycle only
        fu_valid = 2'b01;
        fu_pd[5:0]    = 6'd7;
        fu_rd[4:0]    = 5'd3;
        fu_rob[3:0]   = 4'd2;
        fu_data[31:0] = 32'h0000_1234;
        tick();
        set_fu(0, 1'b0, 6'd0);
        chk("single/c1", 64'({cdb_valid, cdb_pd, cdb_rd, cdb_rob, cdb_data}), 64'd0);
        tick();
        chk("single/c2", 64'({cdb_valid, cdb_pd, cdb_rd, cdb_rob, cdb_data}),
            64'(bus_of(1'b1, 6'd7, 5'd3, 4'd2, 32'h0000_1234)));
        tick();
        chk("single/c3", 64'({cdb_valid, cdb_pd, cdb_rd, cdb_rob, cdb_data}), 64'd0);

        // Reset mid-burst drops both buffered results; also returns the RR pointer to 0
        step("rstmid/c0", 1'b1, 6'h3A, 1'b1, 6'h3B, 2'b00, 1'b0, 6'h00);
        rst = 1'b1;
        step("rstmid/c1", 1'b0, 6'h00, 1'b0, 6'h00, 2'b00, 1'b0, 6'h00);
        rst = 1'b0;
        step("rstmid/c2", 1'b0, 6'h00, 1'b0, 6'h00, 2'b00, 1'b0, 6'h00);
        step("rstmid/c3", 1'b0, 6'h00, 1'b0, 6'h00, 2'b00, 1'b0, 6'h00);
        step("rstmid/c4", 1'b0, 6'h00, 1'b0, 6'h00, 2'b00, 1'b0, 6'h00);

        // Collision: add wins first in both builds (pointer is 0)
        step("coll/c0", 1'b1, 6'd5, 1'b1, 6'd9, 2'b00, 1'b0, 6'd0);
        step("coll/c1", 1'b0, 6'd0, 1'b0, 6'd0, 2'b00, 1'b0, 6'd0);
        step("coll/c2", 1'b0, 6'd0, 1'b0, 6'd0, 2'b00, 1'b1, 6'd5);
        step("coll/c3", 1'b0, 6'd0, 1'b0, 6'd0, 2'b00, 1'b1, 6'd9);
        step("coll/c4", 1'b0, 6'd0, 1'b0, 6'd0, 2'b00, 1'b0, 6'd0);

`ifndef CDB_RR_ARB_EN
        // Backpressure: add streams, mul fills and holds its third result until busy drops
        step("bp/c0",  1'b1, 6'h10, 1'b1, 6'h21, 2'b00, 1'b0, 6'h00);
        step("bp/c1",  1'b1, 6'h11, 1'b1, 6'h22, 2'b00, 1'b0, 6'h00);
        step("bp/c2",  1'b1, 6'h12, 1'b0, 6'h00, 2'b10, 1'b1, 6'h10);
        step("bp/c3",  1'b1, 6'h13, 1'b0, 6'h00, 2'b10, 1'b1, 6'h11);
        step("bp/c4",  1'b1, 6'h14, 1'b0, 6'h00, 2'b10, 1'b1, 6'h12);
        step("bp/c5",  1'b1, 6'h15, 1'b0, 6'h00, 2'b10, 1'b1, 6'h13);
        step("bp/c6",  1'b0, 6'h00, 1'b0, 6'h00, 2'b10, 1'b1, 6'h14);
        step("bp/c7",  1'b0, 6'h00, 1'b0, 6'h00, 2'b10, 1'b1, 6'h15);
        step("bp/c8",  1'b0, 6'h00, 1'b1, 6'h23, 2'b00, 1'b1, 6'h21);
        step("bp/c9",  1'b0, 6'h00, 1'b0, 6'h00, 2'b00, 1'b1, 6'h22);
        step("bp/c10", 1'b0, 6'h00, 1'b0, 6'h00, 2'b00, 1'b1, 6'h23);
        step("bp/c11", 1'b0, 6'h00, 1'b0, 6'h00, 2'b00, 1'b0, 6'h00);
`endif

        // Flush with two results buffered and a new add arriving: nothing ever broadcasts
        step("flush/c0", 1'b1, 6'h31, 1'b1, 6'h32, 2'b00, 1'b0, 6'h00);
        flush = 1'b1;
        step("flush/c1", 1'b1, 6'h33, 1'b0, 6'h00, 2'b00, 1'b0, 6'h00);
        flush = 1'b0;
        step("flush/c2", 1'b0, 6'h00, 1'b0, 6'h00, 2'b00, 1'b0, 6'h00);
        step("flush/c3", 1'b0, 6'h00, 1'b0, 6'h00, 2'b00, 1'b0, 6'h00);
        step("flush/c4", 1'b0, 6'h00, 1'b0, 6'h00, 2'b00, 1'b0, 6'h00);
        step("flush/c5", 1'b1, 6'h34, 1'b0, 6'h00, 2'b00, 1'b0, 6'h00);
        step("flush/c6", 1'b0, 6'h00, 1'b0, 6'h00, 2'b00, 1'b0, 6'h00);
        step("flush/c7", 1'b0, 6'h00, 1'b0, 6'h00, 2'b00, 1'b1, 6'h34);
        step("flush/c8", 1'b0, 6'h00, 1'b0, 6'h00, 2'b00, 1'b0, 6'h00);

`ifdef CDB_RR_ARB_EN
        // Round-robin fairness from pointer 0: grants alternate add, mul for eight cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        step("rr/c0",  1'b1, 6'h10, 1'b1, 6'h20, 2'b00, 1'b0, 6'h00);
        step("rr/c1",  1'b1, 6'h11, 1'b1, 6'h21, 2'b00, 1'b0, 6'h00);
        step("rr/c2",  1'b1, 6'h12, 1'b0, 6'h00, 2'b10, 1'b1, 6'h10);
        step("rr/c3",  1'b0, 6'h00, 1'b1, 6'h22, 2'b01, 1'b1, 6'h20);
        step("rr/c4",  1'b1, 6'h13, 1'b0, 6'h00, 2'b10, 1'b1, 6'h11);
        step("rr/c5",  1'b0, 6'h00, 1'b1, 6'h23, 2'b01, 1'b1, 6'h21);
        step("rr/c6",  1'b0, 6'h00, 1'b0, 6'h00, 2'b10, 1'b1, 6'h12);
        step("rr/c7",  1'b0, 6'h00, 1'b0, 6'h00, 2'b00, 1'b1, 6'h22);
        step("rr/c8",  1'b0, 6'h00, 1'b0, 6'h00, 2'b00, 1'b1, 6'h13);
        step("rr/c9",  1'b0, 6'h00, 1'b0, 6'h00, 2'b00, 1'b1, 6'h23);
        step("rr/c10", 1'b0, 6'h00, 1'b0, 6'h00, 2'b00, 1'b0, 6'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
